// File: rtl/crc_stream_engine_if.sv
// rtl/crc_stream_engine_if.sv - beat stream, FCS stream and result bundle of crc_stream_engine
// master = frame source / FCS sink side, slave = the CRC engine.
interface crc_stream_engine_if #(
  parameter int DATA_W = 4,
  parameter int WIDTH  = 32
);
  logic              check_mode;
  logic              append_en;
  logic              data_valid;
  logic [DATA_W-1:0] data_in;
  logic              sof;
  logic              eof;
  logic              in_ready;
  logic [WIDTH-1:0]  crc_out;
  logic              crc_valid;
  logic              crc_ok;
  logic              fcs_valid;
  logic [DATA_W-1:0] fcs_data;
  logic              fcs_last;
  logic              fcs_ready;
  logic              restart;

  modport master (
    output check_mode, append_en, data_valid, data_in, sof, eof, fcs_ready,
    input  in_ready, crc_out, crc_valid, crc_ok, fcs_valid, fcs_data, fcs_last, restart
  );

  modport slave (
    input  check_mode, append_en, data_valid, data_in, sof, eof, fcs_ready,
    output in_ready, crc_out, crc_valid, crc_ok, fcs_valid, fcs_data, fcs_last, restart
  );
endinterface

// File: rtl/crc_stream_engine.sv
// rtl/crc_stream_engine.sv - parametrised framed CRC generator/checker with optional FCS append
// Results are registered on the eof beat so crc_valid coincides with the DONE state.
module crc_stream_engine #(
  parameter int               WIDTH       = 32,
  parameter int               DATA_W      = 4,
  parameter logic [WIDTH-1:0] POLY        = 32'h04C11DB7,
  parameter logic [WIDTH-1:0] INIT        = '1,
  parameter bit               REFLECT_IN  = 1'b1,
  parameter bit               REFLECT_OUT = 1'b1,
  parameter logic [WIDTH-1:0] XOR_OUT     = '1,
  parameter logic [WIDTH-1:0] RESIDUE     = 32'hC704DD7B
) (
  input  logic                  clk_25Mz,
  input  logic                  rst_n,
  crc_stream_engine_if.slave    bus
);
  localparam int BEATS = WIDTH / DATA_W;
  localparam int CNT_W = $clog2(BEATS + 1);

  typedef enum logic [1:0] {IDLE, ACCUM, DONE, FCS} state_t;

  state_t           state;
  logic [WIDTH-1:0] crc_reg;
  logic [WIDTH-1:0] fcs_shift;
  logic [CNT_W-1:0] fcs_left;
  logic             chk_r;
  logic             app_r;

  logic             accept;
  logic             chk_nxt;
  logic             app_nxt;
  logic [WIDTH-1:0] crc_nxt;

  function automatic logic [WIDTH-1:0] fold(input logic [WIDTH-1:0] c, input logic [DATA_W-1:0] d);
    logic [WIDTH-1:0] r;
    logic             fb;
    r = c;
    for (int i = 0; i < DATA_W; i++) begin
      fb = r[WIDTH-1] ^ (REFLECT_IN ? d[i] : d[DATA_W-1-i]);
      r  = {r[WIDTH-2:0], 1'b0} ^ (fb ? POLY : '0);
    end
    return r;
  endfunction

  function automatic logic [WIDTH-1:0] finalize(input logic [WIDTH-1:0] c);
    logic [WIDTH-1:0] r;
    for (int i = 0; i < WIDTH; i++) r[i] = REFLECT_OUT ? c[WIDTH-1-i] : c[i];
    return r ^ XOR_OUT;
  endfunction

  // A sof beat always restarts from INIT and re-samples the frame mode.
  always_comb begin
    accept  = bus.data_valid & bus.in_ready;
    chk_nxt = bus.sof ? bus.check_mode : chk_r;
    app_nxt = bus.sof ? bus.append_en : app_r;
    crc_nxt = fold(bus.sof ? INIT : crc_reg, bus.data_in);
  end

  always_ff @(posedge clk_25Mz or negedge rst_n) begin
    if (!rst_n) begin
      state         <= IDLE;
      crc_reg       <= INIT;
      fcs_shift     <= '0;
      fcs_left      <= '0;
      chk_r         <= 1'b0;
      app_r         <= 1'b0;
      bus.in_ready  <= 1'b0;
      bus.crc_out   <= '0;
      bus.crc_valid <= 1'b0;
      bus.crc_ok    <= 1'b0;
      bus.fcs_valid <= 1'b0;
      bus.fcs_data  <= '0;
      bus.fcs_last  <= 1'b0;
      bus.restart   <= 1'b0;
    end else begin
      bus.crc_valid <= 1'b0;
      bus.restart   <= 1'b0;
      case (state)
        IDLE, ACCUM: begin
          bus.in_ready <= 1'b1;
          if (accept && (bus.sof || state == ACCUM)) begin
            crc_reg     <= crc_nxt;
            chk_r       <= chk_nxt;
            app_r       <= app_nxt;
            bus.restart <= bus.sof && (state == ACCUM);
            state       <= ACCUM;
            if (bus.eof) begin
              state         <= DONE;
              bus.in_ready  <= 1'b0;
              bus.crc_valid <= 1'b1;
              bus.crc_out   <= finalize(crc_nxt);
              bus.crc_ok    <= chk_nxt && (crc_nxt == RESIDUE);
            end
          end
        end
        DONE: begin
          if (!chk_r && app_r) begin
            state         <= FCS;
            bus.fcs_valid <= 1'b1;
            bus.fcs_data  <= bus.crc_out[DATA_W-1:0];
            fcs_shift     <= bus.crc_out >> DATA_W;
            fcs_left      <= CNT_W'(BEATS - 1);
            bus.fcs_last  <= (BEATS == 1);
          end else begin
            state        <= IDLE;
            bus.in_ready <= 1'b1;
          end
        end
        FCS: begin
          if (bus.fcs_ready) begin
            if (bus.fcs_last) begin
              state         <= IDLE;
              bus.in_ready  <= 1'b1;
              bus.fcs_valid <= 1'b0;
              bus.fcs_last  <= 1'b0;
            end else begin
              bus.fcs_data <= fcs_shift[DATA_W-1:0];
              fcs_shift    <= fcs_shift >> DATA_W;
              fcs_left     <= fcs_left - CNT_W'(1);
              bus.fcs_last <= (fcs_left == CNT_W'(1));
            end
          end
        end
        default: state <= IDLE;
      endcase
    end
  end
endmodule

// File: tb/tb_crc_stream_engine.sv
// tb/tb_crc_stream_engine.sv - self-checking bench for crc_stream_engine (nibble and byte builds)
// Reference is a bytewise reflected CRC-32; inputs driven and outputs sampled on the falling edge.
`timescale 1ns/1ps
module tb_crc_stream_engine;
  logic clk_25Mz = 1'b0;
  logic rst_n;
  always #20 clk_25Mz = ~clk_25Mz;

  crc_stream_engine_if #(.DATA_W(4), .WIDTH(32)) nb ();
  crc_stream_engine_if #(.DATA_W(8), .WIDTH(32)) bb ();

  crc_stream_engine #(.DATA_W(4)) u_nib  (.clk_25Mz(clk_25Mz), .rst_n(rst_n), .bus(nb.slave));
  crc_stream_engine #(.DATA_W(8)) u_byte (.clk_25Mz(clk_25Mz), .rst_n(rst_n), .bus(bb.slave));

  int         vec_cnt = 0;
  int         err_cnt = 0;
  logic [7:0] pay[$];

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    vec_cnt++;
    if (obs !== exp) begin
      err_cnt++;
      $display("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  function automatic logic [31:0] ref_crc();
    logic [31:0] c;
    c = 32'hFFFFFFFF;
    foreach (pay[i]) begin
      c ^= {24'h0, pay[i]};
      repeat (8) c = c[0] ? ((c >> 1) ^ 32'hEDB88320) : (c >> 1);
    end
    return ~c;
  endfunction

  task automatic load_kat();
    pay = {8'h31, 8'h32, 8'h33, 8'h34, 8'h35, 8'h36, 8'h37, 8'h38, 8'h39};
  endtask

  task automatic nib_beats(input int cnt, input bit eof_last);
    for (int i = 0; i < cnt; i++) begin
      nb.data_valid = 1'b1;
      nb.data_in    = i[0] ? pay[i/2][7:4] : pay[i/2][3:0];
      nb.sof        = (i == 0);
      nb.eof        = eof_last && (i == cnt - 1);
      @(negedge clk_25Mz);
      nb.data_valid = 1'b0;
      nb.sof        = 1'b0;
      nb.eof        = 1'b0;
    end
  endtask

  task automatic nib_frame(input bit app, input int rdy_mode, input bit mid);
    logic [31:0] exp_crc;
    logic [4:0]  held;
    int          n, got;
    bit          stalled, rdy;
    exp_crc = ref_crc();
    n = 2 * pay.size();
    nb.check_mode = 1'b0;
    nb.append_en  = app;
    for (int i = 0; i < n; i++) begin
      nb.data_valid = 1'b1;
      nb.data_in    = i[0] ? pay[i/2][7:4] : pay[i/2][3:0];
      nb.sof        = (i == 0);
      nb.eof        = (i == n - 1);
      @(negedge clk_25Mz);
      nb.data_valid = 1'b0;
      nb.sof        = 1'b0;
      nb.eof        = 1'b0;
      if (i < 2 && i < n - 1) chk("nib_restart", nb.restart, (i == 0) && mid);
    end
    chk("nib_crc_valid", nb.crc_valid, 1);
    chk("nib_crc_out", nb.crc_out, exp_crc);
    chk("nib_crc_ok", nb.crc_ok, 0);
    chk("nib_in_ready_done", nb.in_ready, 0);
    @(negedge clk_25Mz);
    chk("nib_crc_pulse", nb.crc_valid, 0);
    chk("nib_fcs_start", nb.fcs_valid, app);
    if (app) begin
      got = 0;
      stalled = 1'b0;
      held = '0;
      for (int c = 0; c < 64 && got < 8; c++) begin
        if (stalled) chk("nib_fcs_hold", {nb.fcs_last, nb.fcs_data}, held);
        rdy = (rdy_mode == 0) ? 1'b1 : (rdy_mode == 1) ? (c % 3 == 0) : 1'($urandom_range(0, 1));
        nb.fcs_ready = rdy;
        chk("nib_fcs_valid", nb.fcs_valid, 1);
        chk("nib_fcs_in_ready", nb.in_ready, 0);
        if (rdy) begin
          chk("nib_fcs_data", nb.fcs_data, exp_crc[4*got +: 4]);
          chk("nib_fcs_last", nb.fcs_last, got == 7);
          got++;
          stalled = 1'b0;
        end else begin
          stalled = 1'b1;
          held = {nb.fcs_last, nb.fcs_data};
        end
        @(negedge clk_25Mz);
      end
      nb.fcs_ready = 1'b0;
      chk("nib_fcs_count", got, 8);
      chk("nib_fcs_end", nb.fcs_valid, 0);
    end
    chk("nib_in_ready_after", nb.in_ready, 1);
  endtask

  task automatic byte_frame(input bit chk_m, input bit exp_ok);
    logic [31:0] exp_crc;
    exp_crc = ref_crc();
    bb.check_mode = chk_m;
    bb.append_en  = 1'b0;
    foreach (pay[i]) begin
      bb.data_valid = 1'b1;
      bb.data_in    = pay[i];
      bb.sof        = (i == 0);
      bb.eof        = (i == pay.size() - 1);
      @(negedge clk_25Mz);
      bb.data_valid = 1'b0;
      bb.sof        = 1'b0;
      bb.eof        = 1'b0;
    end
    chk("byte_crc_valid", bb.crc_valid, 1);
    chk("byte_crc_out", bb.crc_out, exp_crc);
    chk("byte_crc_ok", bb.crc_ok, exp_ok);
    @(negedge clk_25Mz);
    chk("byte_crc_pulse", bb.crc_valid, 0);
    chk("byte_in_ready", bb.in_ready, 1);
  endtask

  task automatic chk_nib_reset(input string tag);
    chk(tag, {nb.in_ready, nb.crc_valid, nb.crc_ok, nb.fcs_valid, nb.fcs_last, nb.restart}, 0);
    chk(tag, {nb.crc_out}, 0);
    chk(tag, {nb.fcs_data}, 0);
  endtask

  initial begin
    logic [31:0] fcs;
    bit          bad;
    int          pos;
    nb.check_mode = 0; nb.append_en = 0; nb.data_valid = 0; nb.data_in = 0;
    nb.sof = 0; nb.eof = 0; nb.fcs_ready = 0;
    bb.check_mode = 0; bb.append_en = 0; bb.data_valid = 0; bb.data_in = 0;
    bb.sof = 0; bb.eof = 0; bb.fcs_ready = 0;
    rst_n = 1'b0;
    repeat (3) @(negedge clk_25Mz);
    chk_nib_reset("rst_nib");
    chk("rst_byte", {bb.in_ready, bb.crc_valid, bb.crc_ok, bb.fcs_valid, bb.restart}, 0);
    rst_n = 1'b1;
    @(negedge clk_25Mz);
    chk("rel_in_ready", {nb.in_ready, bb.in_ready}, 2'b11);

    load_kat();
    byte_frame(0, 0);
    chk("kat_byte", bb.crc_out, 32'hCBF43926);

    nib_frame(1, 0, 0);
    chk("kat_nib", nb.crc_out, 32'hCBF43926);

    pay.push_back(8'h26); pay.push_back(8'h39); pay.push_back(8'hF4); pay.push_back(8'hCB);
    byte_frame(1, 1);
    chk("kat_residue_view", bb.crc_out, 32'h2144DF1C);
    pay[2] ^= 8'h04;
    byte_frame(1, 0);

    load_kat();
    nib_frame(1, 1, 0);

    nb.check_mode = 0; nb.append_en = 0;
    nib_beats(3, 0);
    nib_frame(0, 0, 1);
    chk("kat_restart", nb.crc_out, 32'hCBF43926);

    pay = {8'hA5};
    byte_frame(0, 0);

    load_kat();
    nb.check_mode = 0; nb.append_en = 0;
    nib_beats(5, 0);
    rst_n = 1'b0;
    #1;
    chk_nib_reset("rst_mid_frame");
    @(negedge clk_25Mz);
    rst_n = 1'b1;
    for (int k = 0; k < 4; k++) begin
      @(negedge clk_25Mz);
      chk("rst_no_crc_valid", nb.crc_valid, 0);
    end

    nb.append_en = 1; nb.fcs_ready = 0;
    nib_beats(18, 1);
    repeat (3) @(negedge clk_25Mz);
    chk("fcs_stalled", nb.fcs_valid, 1);
    rst_n = 1'b0;
    #1;
    chk_nib_reset("rst_mid_fcs");
    @(negedge clk_25Mz);
    rst_n = 1'b1;
    @(negedge clk_25Mz);
    chk("rst_fcs_in_ready", nb.in_ready, 1);
    nib_frame(1, 2, 0);
    chk("kat_after_reset", nb.crc_out, 32'hCBF43926);

    for (int r = 0; r < 12; r++) begin
      pay = {};
      repeat ($urandom_range(1, 10)) pay.push_back(8'($urandom));
      nib_frame(1'($urandom_range(0, 1)), 2, 0);
    end

    for (int r = 0; r < 12; r++) begin
      pay = {};
      repeat ($urandom_range(1, 10)) pay.push_back(8'($urandom));
      fcs = ref_crc();
      for (int k = 0; k < 4; k++) pay.push_back(fcs[8*k +: 8]);
      bad = 1'($urandom_range(0, 1));
      if (bad) begin
        pos = $urandom_range(0, pay.size() - 1);
        pay[pos] ^= 8'(1 << $urandom_range(0, 7));
      end
      byte_frame(1, !bad);
    end

    $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
    $finish;
  end

  initial begin
    #2ms;
    $display("FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end
endmodule
